femto_io_responder: RTL and testbench
=====================================

Name: femto_io_responder

Overview:
- IO-region responder on the FemtoRV32 memory bus; the CPU initiates, this block answers.
- Decodes word offsets within the IO window (mem_addr bit 22 set) and implements the registers:
  - PORT_A output latch
  - synchronised PORT_B input
  - free-running cycle counter with compare-match interrupt
- Drives rdata, rbusy and wbusy with a configurable number of wait states.
- Drives the CPU interrupt_request line.

Parameters:
WAIT_STATES, 1, extra busy cycles per access (0..15); 0 means single-cycle response, identical to RAM timing.
PORT_B_WIDTH, 8, width of the PORT_B input.

Ports:
clk  input  1  system clock (48 MHz domain)
reset  input  1  asynchronous, active-low reset
sel  input  1  access targets IO region (mem_addr[22])
addr  input  8  byte offset mem_addr[7:0]; bits [1:0] ignored
wmask  input  4  byte write strobes; nonzero with sel starts a write
wdata  input  32  write data
rstrb  input  1  read strobe; with sel starts a read
rdata  output  32  read data
rbusy  output  1  read in progress
wbusy  output  1  write in progress
port_a  output  8  PORT_A latch
port_b  input  PORT_B_WIDTH  asynchronous external input
irq  output  1  interrupt request to CPU

Behaviour:
- Register map (word offsets):
  - 0x00 PORT_A: rw, bits [7:0], upper bits read 0.
  - 0x04 PORT_B: ro, 2-flop synchronised input, zero-extended.
  - 0x08 COUNTER: ro, 32-bit.
  - 0x0C COMPARE: rw.
  - 0x10 STATUS: bit0 MATCH; writing 1 to bit0 with wmask[0] clears it.
  - 0x14 ENABLE: bit0 rw.
  - All other offsets: read 0, writes ignored, but full handshake still performed.
- Reset values: rdata 0, rbusy 0, wbusy 0, irq 0, port_a 0, COUNTER 0, COMPARE 0xFFFFFFFF, STATUS 0, ENABLE 0, synchroniser 0, FSM IDLE.
- FSM states and transitions:
  - IDLE, READ_WAIT, WRITE_WAIT.
  - IDLE with sel & rstrb sampled at edge N: latch addr and register snapshot.
    - WAIT_STATES=0: rdata valid from N+1; rbusy never asserts; stay IDLE.
    - Else: rbusy=1 for cycles N+1..N+WAIT_STATES; rdata updates and rbusy drops at the edge ending N+WAIT_STATES; return to IDLE.
  - IDLE with sel & wmask!=0 at edge N: register write commits at edge N (byte lanes per wmask); wbusy=1 for WAIT_STATES cycles after; then IDLE.
  - rstrb and wmask together: write takes priority; read ignored.
- Read data content:
  - rdata holds the COUNTER value present during cycle N, not the value at response time.
  - rdata holds its value until the next completed read; writes do not disturb it.
- Strobes arriving in READ_WAIT/WRITE_WAIT are ignored (protocol violation; CPU never does this).
- A wait counter (4 bits) counts busy cycles; reloads on each accepted access.
- COUNTER increments every clock and wraps 0xFFFFFFFF -> 0.
- MATCH:
  - Sets on any cycle where COUNTER == COMPARE.
  - Set and clear in the same cycle: set wins.
  - MATCH is level-latched until cleared.
- irq is registered STATUS[0] & ENABLE[0] (one-cycle delay from MATCH/ENABLE change).
- Writing COMPARE equal to the current COUNTER value does not match in the write cycle; it matches on the next wrap.
- Reset asserted mid-access: immediate return to reset values; pending access dropped; rbusy/wbusy low asynchronously.
- sel low: strobes are ignored entirely; outputs hold.

Test Plan:
- Reset then idle 10 cycles -> port_a=0x00, rbusy=wbusy=irq=0; read 0x0C returns 0xFFFFFFFF.
- WAIT_STATES=1: write 0xA5 to 0x00, wmask=0001 -> port_a=0xA5 at next cycle; wbusy high exactly 1 cycle. Write wmask=0010 with wdata=0x0000FF00 -> port_a unchanged.
- Read 0x08 issued when COUNTER=100 -> rbusy high 1 cycle, rdata=100. Second read 5 cycles later -> rdata=105.
- port_b driven 0x3C at cycle T -> read 0x04 sampled at T+2 returns 0x3C; sampled at T+1 returns the old value.
- COMPARE=COUNTER+20, ENABLE=1 -> STATUS[0] set at match; irq high one cycle later. Write 0x1 to 0x10 -> irq low two cycles later. Clear coinciding with a match -> STATUS stays 1.
- WAIT_STATES=0 build: read and write complete with rbusy/wbusy never asserted. Reset pulse during WAIT_STATES=3 read -> rbusy drops asynchronously; rdata=0.

Source files
------------

// File: rtl/femto_io_responder.sv
// IO-window responder for the FemtoRV32 bus: PORT_A latch, synchronised PORT_B, cycle counter with compare IRQ.
// Latency: a write commits at the accepting edge; read data is ready WAIT_STATES cycles after the accepting edge (next cycle when 0).
// Backpressure: rbusy/wbusy stay high for WAIT_STATES cycles after an access; strobes seen while busy are dropped.
//
// Ports: clk/reset (async, active-low); sel/addr/wmask/wdata/rstrb = CPU request;
//        rdata/rbusy/wbusy = CPU response; port_a = output latch; port_b = async input; irq = interrupt request.
module femto_io_responder #(
    parameter int WAIT_STATES  = 1,
    parameter int PORT_B_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sel,
    input  logic [7:0]              addr,
    input  logic [3:0]              wmask,
    input  logic [31:0]             wdata,
    input  logic                    rstrb,
    output logic [31:0]             rdata,
    output logic                    rbusy,
    output logic                    wbusy,
    output logic [7:0]              port_a,
    input  logic [PORT_B_WIDTH-1:0] port_b,
    output logic                    irq
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] WS       = 4'(WAIT_STATES);
    localparam bit         HAS_WAIT = (WAIT_STATES != 0);

    localparam logic [5:0] REG_PORT_A  = 6'h00;
    localparam logic [5:0] REG_PORT_B  = 6'h01;
    localparam logic [5:0] REG_COUNTER = 6'h02;
    localparam logic [5:0] REG_COMPARE = 6'h03;
    localparam logic [5:0] REG_STATUS  = 6'h04;
    localparam logic [5:0] REG_ENABLE  = 6'h05;

    state_t                  state_q, state_d;
    logic [3:0]              wait_cnt_q, wait_cnt_d;
    logic [31:0]             snap_q, snap_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [7:0]              port_a_q, port_a_d;
    logic [PORT_B_WIDTH-1:0] sync1_q, sync2_q;
    logic [31:0]             counter_q, counter_d;
    logic [31:0]             compare_q, compare_d;
    logic                    match_q, match_d;
    logic                    enable_q, enable_d;
    logic                    irq_q, irq_d;

    logic [5:0]  word;
    logic        wr_go;
    logic        rd_go;
    logic [31:0] rd_mux;

    // Byte offset bits [1:0] carry no meaning for word registers.
    logic addr_unused;
    assign addr_unused = &addr[1:0];

    assign word = addr[7:2];

    always_comb begin
        // Write wins over a simultaneous read strobe.
        wr_go = sel && (wmask != 4'b0000) && (state_q == IDLE);
        rd_go = sel && rstrb && (wmask == 4'b0000) && (state_q == IDLE);

        rd_mux = 32'h0;
        case (word)
            REG_PORT_A:  rd_mux = {24'h0, port_a_q};
            REG_PORT_B:  rd_mux = 32'(sync2_q);
            REG_COUNTER: rd_mux = counter_q;
            REG_COMPARE: rd_mux = compare_q;
            REG_STATUS:  rd_mux = {31'h0, match_q};
            REG_ENABLE:  rd_mux = {31'h0, enable_q};
            default:     rd_mux = 32'h0;
        endcase
    end

    // Register file updates
    always_comb begin
        port_a_d  = port_a_q;
        compare_d = compare_q;
        enable_d  = enable_q;
        match_d   = match_q;
        counter_d = counter_q + 32'd1;
        irq_d     = match_q & enable_q;

        if (wr_go) begin
            case (word)
                REG_PORT_A: if (wmask[0]) port_a_d = wdata[7:0];
                REG_COMPARE: begin
                    for (int i = 0; i < 4; i++) begin
                        if (wmask[i]) compare_d[8*i +: 8] = wdata[8*i +: 8];
                    end
                end
                REG_STATUS: if (wmask[0] && wdata[0]) match_d = 1'b0;
                REG_ENABLE: if (wmask[0]) enable_d = wdata[0];
                default: ;
            endcase
        end

        // Compare uses the pre-write COMPARE value, so a COMPARE written equal to
        // the live counter only matches after the counter wraps. Set beats clear.
        if (counter_q == compare_q) match_d = 1'b1;
    end

    // Access FSM
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        snap_d     = snap_q;
        rdata_d    = rdata_q;

        case (state_q)
            IDLE: begin
                if (wr_go) begin
                    if (HAS_WAIT) begin
                        state_d    = WRITE_WAIT;
                        wait_cnt_d = WS;
                    end
                end else if (rd_go) begin
                    if (HAS_WAIT) begin
                        // Snapshot now so rdata reflects the request cycle, not the response cycle.
                        state_d    = READ_WAIT;
                        wait_cnt_d = WS;
                        snap_d     = rd_mux;
                    end else begin
                        rdata_d = rd_mux;
                    end
                end
            end
            READ_WAIT: begin
                if (wait_cnt_q <= 4'd1) begin
                    state_d    = IDLE;
                    wait_cnt_d = 4'd0;
                    rdata_d    = snap_q;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            WRITE_WAIT: begin
                if (wait_cnt_q <= 4'd1) begin
                    state_d    = IDLE;
                    wait_cnt_d = 4'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            snap_q     <= 32'h0;
            rdata_q    <= 32'h0;
            port_a_q   <= 8'h00;
            sync1_q    <= '0;
            sync2_q    <= '0;
            counter_q  <= 32'h0;
            compare_q  <= 32'hFFFF_FFFF;
            match_q    <= 1'b0;
            enable_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            snap_q     <= snap_d;
            rdata_q    <= rdata_d;
            port_a_q   <= port_a_d;
            sync1_q    <= port_b;
            sync2_q    <= sync1_q;
            counter_q  <= counter_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
            enable_q   <= enable_d;
            irq_q      <= irq_d;
        end
    end

    // Busy flags decode straight from state so reset drops them immediately.
    assign rbusy  = (state_q == READ_WAIT);
    assign wbusy  = (state_q == WRITE_WAIT);
    assign rdata  = rdata_q;
    assign port_a = port_a_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_femto_io_responder.sv
module tb_femto_io_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic [7:0]  addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        rstrb;
    logic [7:0]  port_b;

    logic [31:0] rdata0, rdata1, rdata3;
    logic        rbusy0, rbusy1, rbusy3;
    logic        wbusy0, wbusy1, wbusy3;
    logic [7:0]  port_a0, port_a1, port_a3;
    logic        irq0, irq1, irq3;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] m;          // expected COUNTER value during the current cycle
    logic        seen_busy0 = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m = 32'h0;
        else        m = m + 32'd1;
    end

    always @(negedge clk) if (rbusy0 || wbusy0) seen_busy0 = 1'b1;

    femto_io_responder #(.WAIT_STATES(0), .PORT_B_WIDTH(8)) dut0 (
        .clk(clk), .reset(rst_n), .sel(sel), .addr(addr), .wmask(wmask), .wdata(wdata),
        .rstrb(rstrb), .rdata(rdata0), .rbusy(rbusy0), .wbusy(wbusy0), .port_a(port_a0),
        .port_b(port_b), .irq(irq0));
    femto_io_responder #(.WAIT_STATES(1), .PORT_B_WIDTH(8)) dut1 (
        .clk(clk), .reset(rst_n), .sel(sel), .addr(addr), .wmask(wmask), .wdata(wdata),
        .rstrb(rstrb), .rdata(rdata1), .rbusy(rbusy1), .wbusy(wbusy1), .port_a(port_a1),
        .port_b(port_b), .irq(irq1));
    femto_io_responder #(.WAIT_STATES(3), .PORT_B_WIDTH(8)) dut3 (
        .clk(clk), .reset(rst_n), .sel(sel), .addr(addr), .wmask(wmask), .wdata(wdata),
        .rstrb(rstrb), .rdata(rdata3), .rbusy(rbusy3), .wbusy(wbusy3), .port_a(port_a3),
        .port_b(port_b), .irq(irq3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [7:0] a);
        sel = 1'b1; addr = a; rstrb = 1'b1;
        tick();
        sel = 1'b0; rstrb = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [3:0] wm, input logic [31:0] d);
        sel = 1'b1; addr = a; wmask = wm; wdata = d;
        tick();
        sel = 1'b0; wmask = 4'h0;
    endtask

    task automatic wait_count(input logic [31:0] target);
        int guard = 0;
        while (m < target && guard < 2000) begin
            tick();
            guard++;
        end
        vectors++;
        if (m !== target) begin
            $display("FAIL wait_count got %0d want %0d", m, target);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) tick();
        vectors++;
        if (port_a1 !== 8'h00 || port_a3 !== 8'h00) begin
            $display("FAIL reset_port_a got %h/%h want 00", port_a1, port_a3); miscompares++;
        end
        vectors++;
        if ({rbusy1, wbusy1, irq1, rbusy3, wbusy3, irq3} !== 6'b0) begin
            $display("FAIL reset_flags got %b want 000000", {rbusy1, wbusy1, irq1, rbusy3, wbusy3, irq3});
            miscompares++;
        end
        vectors++;
        if (rdata1 !== 32'h0) begin
            $display("FAIL reset_rdata got %h want 00000000", rdata1); miscompares++;
        end
        do_read(8'h0C);
        repeat (4) tick();
        vectors++;
        if (rdata0 !== 32'hFFFF_FFFF || rdata1 !== 32'hFFFF_FFFF || rdata3 !== 32'hFFFF_FFFF) begin
            $display("FAIL reset_compare got %h/%h/%h want ffffffff", rdata0, rdata1, rdata3);
            miscompares++;
        end
    endtask

    task automatic test_port_a();
        do_write(8'h00, 4'b0001, 32'h0000_00A5);
        vectors++;
        if (port_a1 !== 8'hA5 || port_a0 !== 8'hA5) begin
            $display("FAIL port_a_write got %h/%h want a5", port_a0, port_a1); miscompares++;
        end
        vectors++;
        if (wbusy1 !== 1'b1 || wbusy0 !== 1'b0) begin
            $display("FAIL wbusy_first got ws1=%b ws0=%b want 1/0", wbusy1, wbusy0); miscompares++;
        end
        tick();
        vectors++;
        if (wbusy1 !== 1'b0 || wbusy3 !== 1'b1) begin
            $display("FAIL wbusy_second got ws1=%b ws3=%b want 0/1", wbusy1, wbusy3); miscompares++;
        end
        repeat (3) tick();
        do_write(8'h00, 4'b0010, 32'h0000_FF00);
        vectors++;
        if (port_a1 !== 8'hA5 || port_a3 !== 8'hA5) begin
            $display("FAIL port_a_lane got %h/%h want a5", port_a1, port_a3); miscompares++;
        end
        repeat (4) tick();
        do_read(8'h00);
        repeat (4) tick();
        vectors++;
        if (rdata3 !== 32'h0000_00A5) begin
            $display("FAIL port_a_read got %h want 000000a5", rdata3); miscompares++;
        end
    endtask

    task automatic test_counter_read();
        logic [31:0] issue;
        wait_count(32'd100);
        issue = m;
        do_read(8'h08);
        vectors++;
        if (rbusy1 !== 1'b1 || rbusy0 !== 1'b0) begin
            $display("FAIL cnt_rbusy got ws1=%b ws0=%b want 1/0", rbusy1, rbusy0); miscompares++;
        end
        vectors++;
        if (rdata0 !== issue) begin
            $display("FAIL cnt_rd_ws0 got %0d want %0d", rdata0, issue); miscompares++;
        end
        vectors++;
        if (rdata1 !== 32'h0000_00A5) begin
            $display("FAIL cnt_rd_hold got %h want 000000a5", rdata1); miscompares++;
        end
        tick();
        vectors++;
        if (rbusy1 !== 1'b0 || rdata1 !== issue || rbusy3 !== 1'b1) begin
            $display("FAIL cnt_rd_ws1 got rbusy1=%b rdata1=%0d rbusy3=%b want 0/%0d/1",
                     rbusy1, rdata1, rbusy3, issue);
            miscompares++;
        end
        wait_count(issue + 32'd5);
        do_read(8'h08);
        repeat (4) tick();
        vectors++;
        if (rdata1 !== issue + 32'd5 || rdata3 !== issue + 32'd5) begin
            $display("FAIL cnt_rd_second got %0d/%0d want %0d", rdata1, rdata3, issue + 32'd5);
            miscompares++;
        end
    endtask

    task automatic test_port_b();
        port_b = 8'h3C;
        tick();
        sel = 1'b1; addr = 8'h04; rstrb = 1'b1;
        tick();
        vectors++;
        if (rdata0 !== 32'h0) begin
            $display("FAIL port_b_early got %h want 00000000", rdata0); miscompares++;
        end
        tick();
        sel = 1'b0; rstrb = 1'b0;
        vectors++;
        if (rdata0 !== 32'h0000_003C) begin
            $display("FAIL port_b_sync got %h want 0000003c", rdata0); miscompares++;
        end
        repeat (4) tick();
        vectors++;
        if (rdata1 !== 32'h0 || rdata3 !== 32'h0) begin
            $display("FAIL port_b_snap got %h/%h want 00000000", rdata1, rdata3); miscompares++;
        end
    endtask

    task automatic test_unmapped();
        do_read(8'h0C);
        repeat (4) tick();
        do_write(8'h1C, 4'hF, 32'h1234_5678);
        vectors++;
        if (wbusy1 !== 1'b1 || rdata1 !== 32'hFFFF_FFFF) begin
            $display("FAIL unmapped_write got wbusy1=%b rdata1=%h want 1/ffffffff", wbusy1, rdata1);
            miscompares++;
        end
        repeat (4) tick();
        do_read(8'h18);
        vectors++;
        if (rbusy1 !== 1'b1) begin
            $display("FAIL unmapped_rbusy got %b want 1", rbusy1); miscompares++;
        end
        repeat (4) tick();
        vectors++;
        if (rdata0 !== 32'h0 || rdata3 !== 32'h0) begin
            $display("FAIL unmapped_read got %h/%h want 00000000", rdata0, rdata3); miscompares++;
        end
        // Strobes with sel low must be ignored.
        addr = 8'h00; rstrb = 1'b1; wmask = 4'h1; wdata = 32'h11;
        tick();
        rstrb = 1'b0; wmask = 4'h0;
        vectors++;
        if (rbusy1 !== 1'b0 || wbusy1 !== 1'b0 || rdata0 !== 32'h0 || port_a1 !== 8'hA5) begin
            $display("FAIL sel_low got rbusy1=%b wbusy1=%b rdata0=%h port_a1=%h want 0/0/0/a5",
                     rbusy1, wbusy1, rdata0, port_a1);
            miscompares++;
        end
        repeat (4) tick();
    endtask

    task automatic test_match();
        logic [31:0] c;
        do_write(8'h14, 4'h1, 32'h1);
        repeat (4) tick();
        c = m + 32'd20;
        do_write(8'h0C, 4'hF, c);
        wait_count(c);
        vectors++;
        if (irq1 !== 1'b0) begin
            $display("FAIL match_before got %b want 0", irq1); miscompares++;
        end
        tick();
        vectors++;
        if (irq1 !== 1'b0) begin
            $display("FAIL irq_delay got %b want 0", irq1); miscompares++;
        end
        tick();
        vectors++;
        if (irq0 !== 1'b1 || irq1 !== 1'b1 || irq3 !== 1'b1) begin
            $display("FAIL irq_set got %b%b%b want 111", irq0, irq1, irq3); miscompares++;
        end
        repeat (2) tick();
        do_write(8'h10, 4'h1, 32'h1);
        vectors++;
        if (irq1 !== 1'b1) begin
            $display("FAIL irq_clear_delay got %b want 1", irq1); miscompares++;
        end
        tick();
        vectors++;
        if (irq1 !== 1'b0 || irq3 !== 1'b0) begin
            $display("FAIL irq_clear got %b/%b want 0", irq1, irq3); miscompares++;
        end
        repeat (3) tick();
        do_read(8'h10);
        repeat (4) tick();
        vectors++;
        if (rdata1 !== 32'h0) begin
            $display("FAIL status_cleared got %h want 00000000", rdata1); miscompares++;
        end
        // Clear landing on the matching cycle: set wins.
        c = m + 32'd10;
        do_write(8'h0C, 4'hF, c);
        wait_count(c);
        do_write(8'h10, 4'h1, 32'h1);
        repeat (4) tick();
        do_read(8'h10);
        repeat (4) tick();
        vectors++;
        if (rdata1 !== 32'h1 || rdata3 !== 32'h1 || irq1 !== 1'b1) begin
            $display("FAIL set_beats_clear got %h/%h irq=%b want 1/1/1", rdata1, rdata3, irq1);
            miscompares++;
        end
        // COMPARE written equal to the live counter must not match.
        do_write(8'h10, 4'h1, 32'h1);
        repeat (4) tick();
        c = m;
        do_write(8'h0C, 4'hF, c);
        repeat (4) tick();
        do_read(8'h10);
        repeat (4) tick();
        vectors++;
        if (rdata1 !== 32'h0 || irq1 !== 1'b0) begin
            $display("FAIL compare_eq_now got %h irq=%b want 0/0", rdata1, irq1); miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        do_write(8'h00, 4'h1, 32'h5A);
        repeat (4) tick();
        do_read(8'h08);
        vectors++;
        if (rbusy3 !== 1'b1) begin
            $display("FAIL mid_rbusy got %b want 1", rbusy3); miscompares++;
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (rbusy3 !== 1'b0 || rbusy1 !== 1'b0 || rdata3 !== 32'h0 || port_a3 !== 8'h00) begin
            $display("FAIL mid_reset got rbusy3=%b rbusy1=%b rdata3=%h port_a3=%h want 0/0/0/00",
                     rbusy3, rbusy1, rdata3, port_a3);
            miscompares++;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) tick();
        vectors++;
        if (rbusy3 !== 1'b0 || rdata3 !== 32'h0 || rdata0 !== 32'h0) begin
            $display("FAIL mid_dropped got rbusy3=%b rdata3=%h rdata0=%h want 0/0/0", rbusy3, rdata3, rdata0);
            miscompares++;
        end
        vectors++;
        if (seen_busy0 !== 1'b0) begin
            $display("FAIL ws0_busy got %b want 0", seen_busy0); miscompares++;
        end
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; addr = 8'h0; wmask = 4'h0; wdata = 32'h0;
        rstrb = 1'b0; port_b = 8'h00;
        test_reset();
        test_port_a();
        test_counter_read();
        test_port_b();
        test_unmapped();
        test_match();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
